// File: rtl/quad_pkg.sv
// quad_pkg: Gray-state constants and step classification
// shared by the quadrature decoder and its filter stage.
package quad_pkg;

  localparam logic [1:0] QS_00 = 2'b00;
  localparam logic [1:0] QS_01 = 2'b01;
  localparam logic [1:0] QS_11 = 2'b11;
  localparam logic [1:0] QS_10 = 2'b10;

  typedef enum logic [1:0] {
    STEP_NONE,
    STEP_FWD,
    STEP_REV,
    STEP_ILLEGAL
  } step_e;

  function automatic logic [1:0] fwd_next(logic [1:0] s);
    logic [1:0] n;
    n = QS_00;
    unique case (s)
      QS_00: n = QS_01;
      QS_01: n = QS_11;
      QS_11: n = QS_10;
      QS_10: n = QS_00;
      default: n = QS_00;
    endcase
    return n;
  endfunction

  function automatic step_e classify(logic [1:0] prev,
                                     logic [1:0] cur);
    step_e s;
    s = STEP_NONE;
    unique case (1'b1)
      prev == cur:             s = STEP_NONE;
      (prev ^ cur) == 2'b11:   s = STEP_ILLEGAL;
      fwd_next(prev) == cur:   s = STEP_FWD;
      default:                 s = STEP_REV;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/quad_decoder_if.sv
// quad_decoder_if: pin inputs, error clear and decoded
// position outputs of the quadrature decoder.
interface quad_decoder_if #(
  parameter int CNT_W = 16
);
  logic             in_a;
  logic             in_b;
  logic             err_clr;
  logic [CNT_W-1:0] count;
  logic             dir;
  logic             step_valid;
  logic             err;

  modport master (
    output in_a, in_b, err_clr,
    input  count, dir, step_valid, err
  );

  modport slave (
    input  in_a, in_b, err_clr,
    output count, dir, step_valid, err
  );
endinterface

// File: rtl/quad_glitch_filter.sv
// quad_glitch_filter: 1-bit debounce; output follows input
// only after FILTER_LEN consecutive differing samples.
module quad_glitch_filter #(
  parameter int FILTER_LEN = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);
  localparam int CW = $clog2(FILTER_LEN);
  localparam logic [CW-1:0] LAST = CW'(FILTER_LEN - 1);

  logic          f_q;
  logic [CW-1:0] c_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      f_q <= 1'b0;
      c_q <= '0;
    end else if (din == f_q) begin
      c_q <= '0;
    end else if (c_q == LAST) begin
      f_q <= din;
      c_q <= '0;
    end else begin
      c_q <= c_q + 1'b1;
    end
  end

  assign dout = f_q;
endmodule

// File: rtl/quad_decoder.sv
// quad_decoder: synchronised quadrature decoder with position count.
// Define QUAD_GLITCH_FILTER_EN to add a quad_glitch_filter per channel.
module quad_decoder
  import quad_pkg::*;
#(
  parameter int CNT_W      = 16,
  parameter int FILTER_LEN = 4
) (
  input logic         clk,
  input logic         rst,
  quad_decoder_if.slave q
);
  typedef enum logic {ST_PRIME, ST_RUN} state_e;

  state_e           state_q, state_d;
  logic [1:0]       sync1_q, sync2_q;
  logic [1:0]       cur, prev_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             dir_q, dir_d;
  logic             sv_q, sv_d;
  logic             err_q, err_d;
  step_e            step;

  if (FILTER_LEN < 2 || FILTER_LEN > 255) begin : g_len_chk
    $error("FILTER_LEN must be 2..255");
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 2'b00;
      sync2_q <= 2'b00;
    end else begin
      sync1_q <= {q.in_a, q.in_b};
      sync2_q <= sync1_q;
    end
  end

`ifdef QUAD_GLITCH_FILTER_EN
  quad_glitch_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_a (
    .clk  (clk),
    .rst  (rst),
    .din  (sync2_q[1]),
    .dout (cur[1])
  );
  quad_glitch_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_b (
    .clk  (clk),
    .rst  (rst),
    .din  (sync2_q[0]),
    .dout (cur[0])
  );
`else
  assign cur = sync2_q;
`endif

  assign step = classify(prev_q, cur);

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_PRIME;
    else     state_q <= state_d;
  end

  // Illegal steps override err_clr in the same cycle.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    dir_d   = dir_q;
    sv_d    = 1'b0;
    err_d   = err_q & ~q.err_clr;
    unique case (state_q)
      ST_PRIME: state_d = ST_RUN;
      ST_RUN: begin
        unique case (step)
          STEP_FWD: begin
            count_d = count_q + CNT_W'(1);
            dir_d   = 1'b1;
            sv_d    = 1'b1;
          end
          STEP_REV: begin
            count_d = count_q - CNT_W'(1);
            dir_d   = 1'b0;
            sv_d    = 1'b1;
          end
          STEP_ILLEGAL: err_d = 1'b1;
          default: ;
        endcase
      end
      default: state_d = ST_PRIME;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q  <= 2'b00;
      count_q <= '0;
      dir_q   <= 1'b0;
      sv_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      prev_q  <= cur;
      count_q <= count_d;
      dir_q   <= dir_d;
      sv_q    <= sv_d;
      err_q   <= err_d;
    end
  end

  assign q.count      = count_q;
  assign q.dir        = dir_q;
  assign q.step_valid = sv_q;
  assign q.err        = err_q;
endmodule

// File: tb/tb_quad_decoder.sv
// tb_quad_decoder: scenario tasks plus randomized run checked
// against a position-arithmetic reference model.
module tb_quad_decoder;
  localparam int CNT_W = 16;
  localparam int FL    = 4;
`ifdef QUAD_GLITCH_FILTER_EN
  localparam bit FILT = 1'b1;
  localparam int LAT  = FL + 3;
`else
  localparam bit FILT = 1'b0;
  localparam int LAT  = 3;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  quad_decoder_if #(.CNT_W(CNT_W)) qif();

  quad_decoder #(.CNT_W(CNT_W), .FILTER_LEN(FL)) dut (
    .clk (clk),
    .rst (rst),
    .q   (qif.slave)
  );

  int checks   = 0;
  int failures = 0;
  bit pa = 1'b0;
  bit pb = 1'b0;

  // Reference model state
  logic [1:0]       m_s1, m_s2, m_prev;
  bit               m_fa, m_fb, m_primed;
  bit               qa[$];
  bit               qb[$];
  logic [CNT_W-1:0] m_count;
  bit               m_dir, m_sv, m_err;

  function automatic int gidx(logic [1:0] g);
    case (g)
      2'b00: return 0;
      2'b01: return 1;
      2'b11: return 2;
      default: return 3;
    endcase
  endfunction

  function automatic bit all_eq(bit h[$], bit v);
    for (int i = 0; i < h.size(); i++)
      if (h[i] != v) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_edge(input bit r, input bit a,
                            input bit b, input bit c);
    logic [1:0] cur;
    int d;
    bit ill;
    if (r) begin
      m_s1 = 0; m_s2 = 0; m_prev = 0;
      m_fa = 0; m_fb = 0; m_primed = 0;
      qa.delete(); qb.delete();
      m_count = 0; m_dir = 0; m_sv = 0; m_err = 0;
      return;
    end
    cur = FILT ? {m_fa, m_fb} : m_s2;
    m_sv = 0;
    ill = 0;
    if (!m_primed) begin
      m_primed = 1;
    end else begin
      d = (gidx(cur) - gidx(m_prev) + 4) % 4;
      if (d == 1) begin m_count++; m_dir = 1; m_sv = 1; end
      if (d == 3) begin m_count--; m_dir = 0; m_sv = 1; end
      if (d == 2) ill = 1;
    end
    if (ill) m_err = 1;
    else if (c) m_err = 0;
    m_prev = cur;
    qa.push_back(m_s2[1]);
    qb.push_back(m_s2[0]);
    if (qa.size() > FL) void'(qa.pop_front());
    if (qb.size() > FL) void'(qb.pop_front());
    if (qa.size() == FL && all_eq(qa, !m_fa)) m_fa = !m_fa;
    if (qb.size() == FL && all_eq(qb, !m_fb)) m_fb = !m_fb;
    m_s2 = m_s1;
    m_s1 = {a, b};
  endtask

  task automatic tick(input bit r, input bit c);
    @(negedge clk);
    rst = r;
    qif.in_a = pa;
    qif.in_b = pb;
    qif.err_clr = c;
    @(posedge clk);
    model_edge(r, pa, pb, c);
    #1;
  endtask

  task automatic set_pins(input logic [1:0] g);
    pa = g[1];
    pb = g[0];
  endtask

  task automatic fresh_start();
    set_pins(2'b00);
    tick(1, 0);
    tick(1, 0);
    repeat (LAT + 4) tick(0, 0);
  endtask

  task automatic test_reset();
    int sv_seen;
    set_pins(2'($urandom_range(0, 3)));
    tick(1, 0);
    tick(1, 0);
    checks++;
    if (qif.count !== 16'h0) begin
      failures++;
      $display("FAIL reset_count: got %0h want 0", qif.count);
    end
    checks++;
    if ({qif.dir, qif.step_valid, qif.err} !== 3'b000) begin
      failures++;
      $display("FAIL reset_flags: got %b want 000",
               {qif.dir, qif.step_valid, qif.err});
    end
    set_pins(2'b00);
    sv_seen = 0;
    repeat (LAT + 6) begin
      tick(0, 0);
      if (qif.step_valid === 1'b1) sv_seen++;
    end
    checks++;
    if (sv_seen != 0 || qif.count !== 16'h0) begin
      failures++;
      $display("FAIL reset_prime: got pulses=%0d count=%0h want 0/0",
               sv_seen, qif.count);
    end
  endtask

  task automatic test_forward();
    logic [1:0] seq [4];
    int pulses;
    int hold;
    seq = '{2'b01, 2'b11, 2'b10, 2'b00};
    fresh_start();
    pulses = 0;
    for (int s = 0; s < 4; s++) begin
      set_pins(seq[s]);
      hold = $urandom_range(20, 30);
      for (int k = 1; k <= hold; k++) begin
        tick(0, 0);
        if (qif.step_valid === 1'b1) begin
          pulses++;
          checks++;
          if (k != LAT) begin
            failures++;
            $display("FAIL fwd_latency: got %0d want %0d", k, LAT);
          end
        end
      end
    end
    checks++;
    if (qif.count !== 16'd4 || qif.dir !== 1'b1) begin
      failures++;
      $display("FAIL fwd_count: got %0h/%b want 4/1",
               qif.count, qif.dir);
    end
    checks++;
    if (pulses != 4) begin
      failures++;
      $display("FAIL fwd_pulses: got %0d want 4", pulses);
    end
  endtask

  task automatic test_reverse_wrap();
    fresh_start();
    set_pins(2'b10);
    repeat (LAT + 5) tick(0, 0);
    checks++;
    if (qif.count !== 16'hFFFF || qif.dir !== 1'b0) begin
      failures++;
      $display("FAIL rev_wrap: got %0h/%b want ffff/0",
               qif.count, qif.dir);
    end
    set_pins(2'b00);
    repeat (LAT + 5) tick(0, 0);
    checks++;
    if (qif.count !== 16'h0 || qif.dir !== 1'b1) begin
      failures++;
      $display("FAIL fwd_wrap: got %0h/%b want 0/1",
               qif.count, qif.dir);
    end
  endtask

  task automatic test_glitch();
    int pulses;
    int want;
    logic [CNT_W-1:0] c0;
    fresh_start();
    for (int w = FL - 1; w <= FL; w++) begin
      c0 = qif.count;
      pulses = 0;
      set_pins(2'b10);
      for (int k = 0; k < w; k++) begin
        tick(0, 0);
        if (qif.step_valid === 1'b1) pulses++;
      end
      set_pins(2'b00);
      repeat (LAT + FL + 5) begin
        tick(0, 0);
        if (qif.step_valid === 1'b1) pulses++;
      end
      want = (FILT && w < FL) ? 0 : 2;
      checks++;
      if (pulses != want) begin
        failures++;
        $display("FAIL glitch_w%0d: got %0d pulses want %0d",
                 w, pulses, want);
      end
      checks++;
      if (qif.count !== c0) begin
        failures++;
        $display("FAIL glitch_net: got %0h want %0h", qif.count, c0);
      end
    end
  endtask

  task automatic test_single_cycle();
    int first;
    int second;
    int n;
    fresh_start();
    first = -1;
    second = -1;
    n = 0;
    set_pins(2'b01);
    for (int k = 1; k <= LAT + FL + 6; k++) begin
      tick(0, 0);
      set_pins(2'b00);
      if (qif.step_valid === 1'b1) begin
        n++;
        if (first < 0) first = k;
        else second = k;
      end
    end
    checks++;
    if (FILT) begin
      if (n != 0) begin
        failures++;
        $display("FAIL pulse1: got %0d steps want 0", n);
      end
    end else if (n != 2 || first != 3 || second != 4) begin
      failures++;
      $display("FAIL pulse1: got n=%0d at %0d,%0d want 2 at 3,4",
               n, first, second);
    end
  endtask

  task automatic test_illegal();
    int pulses;
    logic [CNT_W-1:0] c0;
    fresh_start();
    c0 = qif.count;
    pulses = 0;
    set_pins(2'b11);
    repeat (LAT + 2) begin
      tick(0, 0);
      if (qif.step_valid === 1'b1) pulses++;
    end
    checks++;
    if (qif.err !== 1'b1 || qif.count !== c0 || pulses != 0) begin
      failures++;
      $display("FAIL illegal: got err=%b count=%0h pulses=%0d want 1/%0h/0",
               qif.err, qif.count, pulses, c0);
    end
    set_pins(2'b00);
    for (int k = 1; k <= LAT; k++) tick(0, k == LAT);
    checks++;
    if (qif.err !== 1'b1) begin
      failures++;
      $display("FAIL set_wins: got err=%b want 1", qif.err);
    end
    tick(0, 1);
    checks++;
    if (qif.err !== 1'b0) begin
      failures++;
      $display("FAIL err_clr: got err=%b want 0", qif.err);
    end
    tick(0, 0);
    checks++;
    if (qif.err !== 1'b0) begin
      failures++;
      $display("FAIL err_hold0: got err=%b want 0", qif.err);
    end
  endtask

  task automatic test_reset_mid();
    logic [1:0] seq [6];
    int pulses;
    seq = '{2'b01, 2'b11, 2'b10, 2'b00, 2'b01, 2'b11};
    fresh_start();
    for (int s = 0; s < 6; s++) begin
      set_pins(seq[s]);
      repeat (LAT + 3) tick(0, 0);
    end
    checks++;
    if (qif.count !== 16'd6) begin
      failures++;
      $display("FAIL mid_pre: got %0h want 6", qif.count);
    end
    tick(1, 0);
    checks++;
    if (qif.count !== 16'h0 ||
        {qif.dir, qif.step_valid, qif.err} !== 3'b000) begin
      failures++;
      $display("FAIL mid_rst: got %0h/%b want 0/000", qif.count,
               {qif.dir, qif.step_valid, qif.err});
    end
    pulses = 0;
    repeat (LAT + 5) begin
      tick(0, 0);
      if (qif.step_valid === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 0 || qif.count !== 16'h0) begin
      failures++;
      $display("FAIL mid_reprime: got pulses=%0d count=%0h want 0/0",
               pulses, qif.count);
    end
    set_pins(2'b10);
    repeat (LAT + 3) tick(0, 0);
    checks++;
    if (qif.count !== 16'd1 || qif.dir !== 1'b1) begin
      failures++;
      $display("FAIL mid_step: got %0h/%b want 1/1",
               qif.count, qif.dir);
    end
  endtask

  task automatic test_random();
    int hold;
    bit r;
    bit c;
    hold = 0;
    fresh_start();
    for (int n = 0; n < 3000; n++) begin
      if (hold == 0) begin
        set_pins(2'($urandom_range(0, 3)));
        hold = ($urandom_range(0, 3) == 0) ?
               int'($urandom_range(1, 3)) :
               int'($urandom_range(FL + 1, 20));
      end
      hold--;
      r = ($urandom_range(0, 299) == 0);
      c = ($urandom_range(0, 7) == 0);
      tick(r, c);
      checks++;
      if (qif.count !== m_count || qif.dir !== m_dir ||
          qif.step_valid !== m_sv || qif.err !== m_err) begin
        failures++;
        $display("FAIL rand@%0d: got %0h/%b/%b/%b want %0h/%b/%b/%b",
                 n, qif.count, qif.dir, qif.step_valid, qif.err,
                 m_count, m_dir, m_sv, m_err);
      end
    end
  endtask

  initial begin
    qif.in_a = 1'b0;
    qif.in_b = 1'b0;
    qif.err_clr = 1'b0;
    test_reset();
    test_forward();
    test_reverse_wrap();
    test_glitch();
    test_single_cycle();
    test_illegal();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
